// File: rtl/gshare_predictor.sv
// Gshare direction predictor: fetch PC xor speculative global history indexes a PHT of 2-bit counters.
// Define GSHARE_BYPASS_EN to forward the counter being trained this cycle to a colliding fetch read.
module gshare_predictor #(
    parameter int PHT_INDEX_BITS = 10,
    parameter int GHR_BITS       = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    output logic                      global_predictF,
    output logic [PHT_INDEX_BITS-1:0] pht_indexF,
    input  logic                      branchD,
    input  logic                      stallD,
    input  logic                      global_predictD,
    input  logic                      branchE,
    input  logic                      actual_takenE,
    input  logic                      global_predictE,
    input  logic [PHT_INDEX_BITS-1:0] pht_indexE,
    output logic                      mispredictE
);

    localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;

    logic [1:0]          pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr_spec;
    logic [GHR_BITS-1:0] ghr_arch;
    logic [GHR_BITS-1:0] ghr_arch_shifted;
    logic [GHR_BITS-1:0] ghr_spec_shifted;
    logic [1:0]          ctr_e;
    logic [1:0]          ctr_e_next;
    logic [1:0]          ctr_f;
    logic                unused_pc_bits;

    // Word-aligned PC bits above the index never reach the hash.
    assign unused_pc_bits = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0]};

    assign pht_indexF  = pcF[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(ghr_spec);
    assign mispredictE = branchE & (actual_takenE != global_predictE);

    if (GHR_BITS == 1) begin : g_ghr_single
        assign ghr_arch_shifted = actual_takenE;
        assign ghr_spec_shifted = global_predictD;
    end else begin : g_ghr_multi
        assign ghr_arch_shifted = {ghr_arch[GHR_BITS-2:0], actual_takenE};
        assign ghr_spec_shifted = {ghr_spec[GHR_BITS-2:0], global_predictD};
    end

    assign ctr_e = pht[pht_indexE];

    // NOTE: default first so every path assigns ctr_e_next and no latch is inferred.
    always_comb begin
        ctr_e_next = ctr_e;
        if (actual_takenE) begin
            if (ctr_e != 2'b11) ctr_e_next = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_e_next = ctr_e - 2'd1;
        end
    end

`ifdef GSHARE_BYPASS_EN
    assign ctr_f = (branchE && (pht_indexE == pht_indexF)) ? ctr_e_next : pht[pht_indexF];
`else
    assign ctr_f = pht[pht_indexF];
`endif
    assign global_predictF = ctr_f[1];

    // NOTE: the PHT is built from flops, not RAM, because every entry must reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
        end else if (branchE) begin
            pht[pht_indexE] <= ctr_e_next;
        end
    end

    // NOTE: non-blocking updates so both history registers see each other's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_spec <= '0;
            ghr_arch <= '0;
        end else begin
            if (branchE) ghr_arch <= ghr_arch_shifted;
            // A mispredict flushes D, so the restore from architectural history wins.
            if (mispredictE)             ghr_spec <= ghr_arch_shifted;
            else if (branchD && !stallD) ghr_spec <= ghr_spec_shifted;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table plus randomized cycles vs a model.
module tb_gshare_predictor;

    localparam int IB    = 10;
    localparam int GB    = 10;
    localparam int N     = 1 << IB;
    localparam int GMASK = (1 << GB) - 1;
`ifdef GSHARE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pcF;
    logic          global_predictF;
    logic [IB-1:0] pht_indexF;
    logic          branchD, stallD, global_predictD;
    logic          branchE, actual_takenE, global_predictE;
    logic [IB-1:0] pht_indexE;
    logic          mispredictE;

    gshare_predictor #(.PHT_INDEX_BITS(IB), .GHR_BITS(GB)) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .global_predictF(global_predictF), .pht_indexF(pht_indexF),
        .branchD(branchD), .stallD(stallD), .global_predictD(global_predictD),
        .branchE(branchE), .actual_takenE(actual_takenE), .global_predictE(global_predictE),
        .pht_indexE(pht_indexE), .mispredictE(mispredictE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic          bd, sd, pd, be, at, pe;
        logic [IB-1:0] ie;
        logic          exp_pred;
        logic [IB-1:0] exp_idx;
        logic          exp_mis;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: counters as plain integers 0..3, histories as integers shifted arithmetically.
    int pht_m[N];
    int spec_m, arch_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input logic up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int model_idx(input logic [31:0] pc);
        return ((pc >> 2) & (N - 1)) ^ spec_m;
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        int idx = model_idx(pc);
        int c   = pht_m[idx];
        if (BYP && branchE && (int'(pht_indexE) == idx)) c = sat(c, actual_takenE);
        return c >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) pht_m[i] = 1;
        spec_m = 0;
        arch_m = 0;
    endtask

    task automatic model_clock();
        int old_arch = arch_m;
        if (branchE) begin
            pht_m[pht_indexE] = sat(pht_m[pht_indexE], actual_takenE);
            arch_m = ((old_arch << 1) | int'(actual_takenE)) & GMASK;
        end
        if (branchE && (actual_takenE != global_predictE))
            spec_m = ((old_arch << 1) | int'(actual_takenE)) & GMASK;
        else if (branchD && !stallD)
            spec_m = ((spec_m << 1) | int'(global_predictD)) & GMASK;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input vec_t v);
        pcF = v.pc; branchD = v.bd; stallD = v.sd; global_predictD = v.pd;
        branchE = v.be; actual_takenE = v.at; global_predictE = v.pe; pht_indexE = v.ie;
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic bd, sd, pd, be, at, pe,
                                input logic [IB-1:0] ie, input logic ep,
                                input logic [IB-1:0] eidx, input logic em);
        vec_t v;
        v.pc = pc; v.bd = bd; v.sd = sd; v.pd = pd; v.be = be; v.at = at; v.pe = pe; v.ie = ie;
        v.exp_pred = ep; v.exp_idx = eidx; v.exp_mis = em;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] arch_pat;
        arch_pat = 10'h0A0;

        // Out of reset: index is the plain PC slice, everything predicts not-taken.
        vecs.push_back(mk(32'h1234, 0,0,0, 0,0,0, 10'd0,   1'b0, 10'h08D, 1'b0));
        // Saturate entry 5 while fetching a neighbour, then step it back down.
        repeat (4) vecs.push_back(mk(32'h18, 0,0,0, 1,1,1, 10'd5, 1'b0, 10'd6, 1'b0));
        vecs.push_back(mk(32'h14, 0,0,0, 0,0,0, 10'd0, 1'b1, 10'd5, 1'b0));
        vecs.push_back(mk(32'h18, 0,0,0, 1,0,0, 10'd5, 1'b0, 10'd6, 1'b0));
        vecs.push_back(mk(32'h14, 0,0,0, 0,0,0, 10'd0, 1'b1, 10'd5, 1'b0));
        repeat (2) vecs.push_back(mk(32'h18, 0,0,0, 1,0,0, 10'd5, 1'b0, 10'd6, 1'b0));
        vecs.push_back(mk(32'h14, 0,0,0, 0,0,0, 10'd0, 1'b0, 10'd5, 1'b0));
        // Speculative shift of three taken predictions into the hash.
        vecs.push_back(mk(32'h40, 1,0,1, 0,0,0, 10'd0, 1'b0, 10'h010, 1'b0));
        vecs.push_back(mk(32'h40, 1,0,1, 0,0,0, 10'd0, 1'b0, 10'h011, 1'b0));
        vecs.push_back(mk(32'h40, 1,0,1, 0,0,0, 10'd0, 1'b0, 10'h013, 1'b0));
        vecs.push_back(mk(32'h40, 0,0,0, 0,0,0, 10'd0, 1'b0, 10'h017, 1'b0));
        // Stalled branch in D shifts exactly once, when the stall clears.
        repeat (4) vecs.push_back(mk(32'h40, 1,1,0, 0,0,0, 10'd0, 1'b0, 10'h017, 1'b0));
        vecs.push_back(mk(32'h40, 1,0,0, 0,0,0, 10'd0, 1'b0, 10'h017, 1'b0));
        repeat (2) vecs.push_back(mk(32'h40, 0,0,0, 0,0,0, 10'd0, 1'b0, 10'h01E, 1'b0));
        // Build ghr_arch = 0x0A0 with correctly predicted branches.
        for (int k = 9; k >= 0; k--)
            vecs.push_back(mk(32'h40, 0,0,0, 1,arch_pat[k],arch_pat[k], 10'h3FF, 1'b0, 10'h01E, 1'b0));
        // Mispredict and a D branch together: restore wins.
        vecs.push_back(mk(32'h40, 1,0,1, 1,1,0, 10'h3FF, 1'b0, 10'h01E, 1'b1));
        vecs.push_back(mk(32'h40, 0,0,0, 0,0,0, 10'd0,   1'b0, 10'h151, 1'b0));
        // F/E collision on entry 9 (history now 0x141).
        vecs.push_back(mk(32'h520, 0,0,0, 1,1,1, 10'd9, BYP,  10'd9, 1'b0));
        vecs.push_back(mk(32'h520, 0,0,0, 0,0,0, 10'd0, 1'b1, 10'd9, 1'b0));

        rst = 1'b0;
        drive(mk(32'hABC, 0,0,0, 0,0,0, 10'd0, 1'b0, 10'd0, 1'b0));
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset pred", global_predictF, 1'b0);
        check("reset idx", pht_indexF, 32'h2AF);
        check("reset mis", mispredictE, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d pred", i), global_predictF, vecs[i].exp_pred);
            check($sformatf("vec%0d idx", i), pht_indexF, vecs[i].exp_idx);
            check($sformatf("vec%0d mis", i), mispredictE, vecs[i].exp_mis);
            tick();
        end

        // Reset while a taken update to entry 9 is pending: counter and history both return to reset.
        drive(mk(32'h24, 0,0,0, 1,1,1, 10'd9, 1'b0, 10'd0, 1'b0));
        #2 rst = 1'b0;
        #2 branchE = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #3;
        check("midreset pred", global_predictF, 1'b0);
        check("midreset idx", pht_indexF, 32'd9);
        #1;

        for (int c = 0; c < 3000; c++) begin
            int eidx;
            pcF             = $urandom;
            branchD         = 1'($urandom_range(0, 1));
            stallD          = ($urandom_range(0, 3) == 0);
            global_predictD = 1'($urandom_range(0, 1));
            branchE         = 1'($urandom_range(0, 1));
            actual_takenE   = ($urandom_range(0, 2) != 0);
            global_predictE = 1'($urandom_range(0, 1));
            eidx            = model_idx(pcF);
            pht_indexE      = ($urandom_range(0, 2) == 0) ? IB'(eidx) : IB'($urandom_range(0, 15));
            #3;
            check("rnd idx", pht_indexF, 32'(eidx));
            check("rnd pred", global_predictF, model_pred(pcF));
            check("rnd mis", mispredictE, branchE && (actual_takenE != global_predictE));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
